// File: rtl/cop_pkg.sv
// Shared constants for the custom co-processor: result width default,
// register-index width and the CUSTOM_0..3 major opcodes.
package cop_pkg;
    localparam int XLEN_DEF  = 64;
    localparam int REG_IDX_W = 5;

    typedef enum logic [6:0] {
        CUSTOM_0 = 7'b000_1011,
        CUSTOM_1 = 7'b010_1011,
        CUSTOM_2 = 7'b101_1011,
        CUSTOM_3 = 7'b111_1011
    } cop_opcode_e;

    function automatic logic is_custom_op(input logic [6:0] opcode);
        return (opcode == CUSTOM_0) || (opcode == CUSTOM_1) ||
               (opcode == CUSTOM_2) || (opcode == CUSTOM_3);
    endfunction
endpackage

// File: rtl/cop_wb_buf_if.sv
// Result/write-back handshake bundle between co-processor, buffer and core.
// master = the surrounding pipeline, slave = the write-back buffer.
interface cop_wb_buf_if #(
    parameter int XLEN = cop_pkg::XLEN_DEF
);
    import cop_pkg::*;

    logic                 cop_wr;
    logic [XLEN-1:0]      cop_rd;
    logic [REG_IDX_W-1:0] cop_rd_idx;
    logic                 cop_rdywr;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [XLEN-1:0]      wb_data;
    logic [REG_IDX_W-1:0] wb_idx;
    logic                 wb_flush;
    logic [15:0]          stall_cnt;

    modport master (
        output cop_wr, cop_rd, cop_rd_idx, wb_ready, wb_flush,
        input  cop_rdywr, wb_valid, wb_data, wb_idx, stall_cnt
    );

    modport slave (
        input  cop_wr, cop_rd, cop_rd_idx, wb_ready, wb_flush,
        output cop_rdywr, wb_valid, wb_data, wb_idx, stall_cnt
    );
endinterface

// File: rtl/cop_wb_fifo.sv
// Storage ring for buffered write-back entries. DEPTH is a power of two,
// so the read/write pointers wrap by plain overflow.
module cop_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 69
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;

    // Pointer advance; flush drops any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (rst_n && push && !flush) mem_r[wr_ptr_r] <= wdata;
    end

    assign rdata = mem_r[rd_ptr_r];
endmodule

// File: rtl/cop_wb_buf.sv
// Co-processor write-back buffer: queues results until the core write-back port takes them.
// Optional macro COP_WB_BYPASS_EN forwards a result straight through when the buffer is empty.
module cop_wb_buf #(
    parameter int DEPTH = 2,
    parameter int XLEN  = cop_pkg::XLEN_DEF
) (
    input logic         cop_clk,
    input logic         cop_rst,
    cop_wb_buf_if.slave bus
);
    import cop_pkg::*;

    localparam int ENT_W = REG_IDX_W + XLEN;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;
    logic [15:0]      stall_r;
    logic [ENT_W-1:0] head_s;
    logic             empty_s;
    logic             full_s;
    logic             rdywr_s;
    logic             accept_s;
    logic             bypass_take_s;
    logic             fifo_push_s;
    logic             fifo_pop_s;

    assign empty_s     = (count_r == '0);
    assign full_s      = (count_r == CNT_FULL);
    // When full, wb_valid is necessarily high, so a ready core frees a slot this cycle.
    assign rdywr_s     = !full_s || bus.wb_ready;
    assign accept_s    = bus.cop_wr && rdywr_s;
    assign fifo_push_s = accept_s && !bypass_take_s;
    assign fifo_pop_s  = !empty_s && bus.wb_ready;

    assign bus.cop_rdywr = rdywr_s;
    assign bus.stall_cnt = stall_r;

    cop_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (cop_clk),
        .rst_n (cop_rst),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .flush (bus.wb_flush),
        .wdata ({bus.cop_rd_idx, bus.cop_rd}),
        .rdata (head_s)
    );

    // Write-back head: buffered entry, zero when empty, or the live result when bypassing.
    always_comb begin
        bus.wb_valid  = !empty_s;
        bus.wb_data   = '0;
        bus.wb_idx    = '0;
        bypass_take_s = 1'b0;
        if (!empty_s) begin
            bus.wb_data = head_s[XLEN-1:0];
            bus.wb_idx  = head_s[ENT_W-1 -: REG_IDX_W];
        end else begin
            bus.wb_data = '0;
            bus.wb_idx  = '0;
        end
`ifdef COP_WB_BYPASS_EN
        if (empty_s && bus.cop_wr) begin
            bus.wb_valid  = 1'b1;
            bus.wb_data   = bus.cop_rd;
            bus.wb_idx    = bus.cop_rd_idx;
            bypass_take_s = bus.wb_ready;
        end else begin
            bypass_take_s = 1'b0;
        end
`endif
    end

    // Occupancy count; the sole fullness indicator.
    always_ff @(posedge cop_clk) begin
        if (!cop_rst) begin
            count_r <= '0;
        end else if (bus.wb_flush) begin
            count_r <= '0;
        end else if (fifo_push_s && !fifo_pop_s) begin
            count_r <= count_r + CNT_ONE;
        end else if (!fifo_push_s && fifo_pop_s) begin
            count_r <= count_r - CNT_ONE;
        end
    end

    // Saturating back-pressure counter; survives flush.
    always_ff @(posedge cop_clk) begin
        if (!cop_rst) begin
            stall_r <= 16'd0;
        end else if (bus.cop_wr && !rdywr_s && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'd1;
        end
    end
endmodule
